serial_alu_seq: RTL and testbench

//  Bit-serial ALU sequencer: runs one WIDTH-bit ALU operation through a single ALU_1BIT slice over WIDTH cycles.

---
 rtl/alu_pkg.sv | 11 +
 rtl/ALU_1BIT.sv | 28 ++
 rtl/serial_alu_seq.sv | 94 +++++++++
 tb/tb_serial_alu_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: op codes, alu_ctrl field positions and FSM encoding for the serial ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SLT = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam int CTRL_AINV = 4;
  localparam int CTRL_BINV = 3;
  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
endpackage

// File: rtl/ALU_1BIT.sv
// ALU_1BIT: one-bit ALU slice with operand inversion, full adder and SLT less pass-through.
module ALU_1BIT
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic       carry_in_i,
  input  logic       less_i,
  input  logic [2:0] operation_i,
  output logic       result_o,
  output logic       sum_o,
  output logic       carry_out_o
);
  logic aa, bb;
  assign aa = a_i ^ a_invert_i;
  assign bb = b_i ^ b_invert_i;
  assign sum_o = aa ^ bb ^ carry_in_i;
  assign carry_out_o = (aa & bb) | (aa & carry_in_i) | (bb & carry_in_i);
  always_comb begin
    result_o = operation_i == OP_AND ? aa & bb :
               operation_i == OP_OR  ? aa | bb :
               operation_i == OP_ADD ? sum_o :
               operation_i == OP_SLT ? less_i :
               operation_i == OP_XOR ? aa ^ bb : 1'b0;
  end
endmodule

// File: rtl/serial_alu_seq.sv
// serial_alu_seq: bit-serial ALU sequencer driving one ALU_1BIT slice LSB-first over WIDTH cycles.
// SERIAL_ALU_OVF_EN enables signed overflow and the overflow-corrected SLT.
module serial_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [4:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow,
  output logic             op_err
);
  localparam int CNT_W = $clog2(WIDTH);
  state_e           state_q;
  logic [WIDTH-1:0] a_sr_q, b_sr_q, res_sr_q, result_d;
  logic [4:0]       ctrl_q;
  logic [CNT_W-1:0] cnt_q;
  logic             cy_q, s_res, s_sum, s_co, add_op, ill_op, ovf_d, set_d;
  ALU_1BIT u_slice (
    .a_i(a_sr_q[0]), .b_i(b_sr_q[0]),
    .a_invert_i(ctrl_q[CTRL_AINV]), .b_invert_i(ctrl_q[CTRL_BINV]),
    .carry_in_i(cy_q), .less_i(1'b0), .operation_i(ctrl_q[2:0]),
    .result_o(s_res), .sum_o(s_sum), .carry_out_o(s_co)
  );
  assign busy = state_q != ST_IDLE;
  assign done = state_q == ST_DONE;
  // Flag inputs below are only meaningful on the MSB step, where cy_q is the carry into the MSB.
  always_comb begin
    add_op = ctrl_q[2:0] == OP_ADD || ctrl_q[2:0] == OP_SLT;
    ill_op = ctrl_q[2:0] > OP_XOR;
`ifdef SERIAL_ALU_OVF_EN
    ovf_d = add_op ? cy_q ^ s_co : 1'b0;
    set_d = s_sum ^ ovf_d;
`else
    ovf_d = 1'b0;
    set_d = s_sum;
`endif
    result_d = ill_op ? '0 :
               ctrl_q[2:0] == OP_SLT ? {{(WIDTH-1){1'b0}}, set_d} :
               {s_res, res_sr_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      a_sr_q    <= '0;
      b_sr_q    <= '0;
      res_sr_q  <= '0;
      ctrl_q    <= '0;
      cnt_q     <= '0;
      cy_q      <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      op_err    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          a_sr_q  <= a;
          b_sr_q  <= b;
          ctrl_q  <= alu_ctrl;
          cy_q    <= alu_ctrl[CTRL_BINV];
          cnt_q   <= '0;
          state_q <= ST_RUN;
        end
        ST_RUN: begin
          a_sr_q   <= a_sr_q >> 1;
          b_sr_q   <= b_sr_q >> 1;
          res_sr_q <= {s_res, res_sr_q[WIDTH-1:1]};
          cy_q     <= s_co;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q   <= ST_DONE;
            result    <= result_d;
            zero      <= result_d == '0;
            carry_out <= add_op && !ill_op ? s_co : 1'b0;
            overflow  <= ovf_d;
            op_err    <= ill_op;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_seq.sv
// tb_serial_alu_seq: scoreboard bench for serial_alu_seq against an arithmetic reference model.
module tb_serial_alu_seq;
  localparam int W = 24;
  typedef struct {
    logic [W-1:0] r;
    logic z, c, v, e;
    int acc;
  } exp_t;
  logic clk = 0, reset = 1, start = 0;
  logic [W-1:0] a = '0, b = '0, result;
  logic [4:0] alu_ctrl = '0;
  logic busy, done, zero, carry_out, overflow, op_err, prev_done = 0;
  int cyc = 0, n_chk = 0, n_fail = 0;
  exp_t q[$];
  serial_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .alu_ctrl(alu_ctrl),
    .busy(busy), .done(done), .result(result), .zero(zero), .carry_out(carry_out),
    .overflow(overflow), .op_err(op_err)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    logic [W-1:0] aa, bb;
    logic [W:0] s;
    logic sv, ovf;
    int op;
    aa = c[4] ? ~x : x;
    bb = c[3] ? ~y : y;
    s = {1'b0, aa} + {1'b0, bb} + (W+1)'(c[3]);
    sv = (aa[W-1] == bb[W-1]) && (s[W-1] != aa[W-1]);
    op = int'(c[2:0]);
`ifdef SERIAL_ALU_OVF_EN
    ovf = (op == 2 || op == 3) ? sv : 1'b0;
`else
    ovf = 1'b0;
`endif
    m.r = op == 0 ? aa & bb : op == 1 ? aa | bb : op == 2 ? s[W-1:0] :
          op == 3 ? W'(s[W-1] ^ ovf) : op == 4 ? aa ^ bb : '0;
    m.z = m.r == '0;
    m.c = (op == 2 || op == 3) ? s[W] : 1'b0;
    m.v = ovf;
    m.e = op > 4;
    m.acc = 0;
    return m;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (done) begin
      chk("done_width", 32'(prev_done), 0);
      if (q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_done act=1 exp=0 t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("result", 32'(result), 32'(e.r));
        chk("zero", 32'(zero), 32'(e.z));
        chk("carry_out", 32'(carry_out), 32'(e.c));
        chk("overflow", 32'(overflow), 32'(e.v));
        chk("op_err", 32'(op_err), 32'(e.e));
        chk("latency", 32'(cyc - e.acc), W);
      end
    end
    prev_done = done;
  end
  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin @(posedge clk); #1; k++; end
    if (busy) chk("idle_timeout", 1, 0);
  endtask
  task automatic run_op(input logic [4:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t m;
    wait_idle();
    alu_ctrl = c; a = x; b = y; start = 1;
    @(posedge clk); #1;
    start = 0;
    m = model(c, x, y);
    m.acc = cyc;
    q.push_back(m);
  endtask
  task automatic drain();
    int k = 0;
    while ((q.size() != 0 || busy) && k < 200) begin @(posedge clk); #1; k++; end
    chk("drain_pending", 32'(q.size()), 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_flags", {28'd0, zero, carry_out, overflow, op_err}, 0);
    reset = 0;
    run_op(5'b00010, 24'h000001, 24'hFFFFFF);
    run_op(5'b01010, 24'd5, 24'd7);
    run_op(5'b01011, 24'd3, 24'd5);
    run_op(5'b01011, 24'h800000, 24'd1);
    run_op(5'b11000, 24'h0F0F0F, 24'h00FF00);
    run_op(5'b00100, 24'h0F0F0F, 24'h00FF00);
    run_op(5'b00110, 24'hFFFFFF, 24'hFFFFFF);
    drain();
    run_op(5'b00010, 24'd100, 24'd23);
    repeat (3) @(posedge clk);
    #1;
    alu_ctrl = 5'b00001; a = 24'hABCDEF; b = 24'h123456; start = 1;
    repeat (3) @(posedge clk);
    #1;
    start = 0;
    drain();
    run_op(5'b00010, 24'h123456, 24'h111111);
    repeat (10) @(posedge clk);
    #1;
    q.delete();
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_done", 32'(done), 0);
    repeat (30) @(posedge clk);
    #1;
    run_op(5'b00010, 24'd2, 24'd2);
    for (int i = 0; i < 40; i++)
      run_op(5'($urandom_range(0, 31)), W'($urandom), W'($urandom));
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
